rvv_vd_writeback: RTL and testbench
===================================

// Module: rvv_vd_writeback
// PURPOSE
//  Consumer end of the vector ALU lane interface. Collects per-lane element results
//  (data, element index, valid) into a VLEN-wide destination buffer seeded with old vd.
//  Applies vl tail-undisturbed and optional v0 masking, then issues one
//  valid/ready write (data plus byte enables) to the vector register file.
// PARAMETERS
//  VLEN        128   vector register width in bits (multiple of 64, <=1024)
//  NB_LANES    1     log2 of lane count (lanes = 1<<NB_LANES, max 3)
// PORTS
//  clk         in   1                 clock
//  resetn      in   1                 synchronous, active-low reset
//  start       in   1                 begin instruction; latches vd_old/vsew/vl(/vm,v0_mask)
//  vd_old      in   VLEN              current vd contents (tail/inactive elements kept)
//  vsew        in   3                 element width code: 0=8,1=16,2=32,3=64 bits
//  vl          in   11                active element count
//  lane_vd     in   64<<NB_LANES      per-lane result; element in low SEW bits of each 64b slot
//  lane_idx    in   10<<NB_LANES      per-lane element index
//  lane_valid  in   1<<NB_LANES       per-lane result strobe
//  alu_done    in   1                 last lane results present this cycle
//  vm          in   1                 [RVV_WB_MASK_EN] 1=unmasked, 0=use v0_mask
//  v0_mask     in   VLEN              [RVV_WB_MASK_EN] bit i enables element i
//  wr_valid    out  1                 write request to register file
//  wr_ready    in   1                 register file accepts write
//  wr_data     out  VLEN              assembled vd
//  wr_be       out  VLEN/8            byte enables of elements written this instruction
//  busy        out  1                 state != IDLE
//  done        out  1                 one-cycle completion pulse
// BEHAVIOUR
//  Reset: state=IDLE; wr_valid=0, busy=0, done=0, wr_be=0, wr_data=0.
//  States IDLE -> COLLECT -> WRITE -> IDLE.
//  IDLE: start=1 latches inputs; buf<=vd_old, be<=0. vsew>3 or vl==0 -> no write,
//    stay IDLE, done=1 next cycle. Otherwise -> COLLECT.
//  COLLECT: per cycle, for each lane j with lane_valid[j], element written when
//    idx < min(vl, VLEN>>(vsew+3)) and element active. Write puts lane_vd[j][SEW-1:0]
//    at bit offset idx<<(vsew+3) and sets its SEW/8 be bits. Otherwise dropped silently.
//    Same idx on two lanes in one cycle: higher lane wins. Later writes to the same idx overwrite.
//    alu_done: that cycle's lane data is still captured; next cycle -> WRITE.
//  WRITE: wr_valid=1, wr_data=buf, wr_be=be, both stable until wr_ready. lane_valid ignored.
//    Handshake (wr_valid&&wr_ready) -> IDLE; done=1 the following cycle, for one cycle.
//  Latency: alu_done at cycle T -> wr_valid at T+1. Zero-wait ready -> done at T+2.
//  start while busy is ignored. start coincident with done is accepted.
//  resetn low mid-operation: back to IDLE next edge; pending write discarded, no done.
// CONFIGURATION
//  RVV_WB_MASK_EN defined: vm/v0_mask ports exist and are latched at start. Element i is
//    active iff vm || v0_mask_q[i]. Inactive elements keep vd_old and have be=0.
//  Undefined: vm/v0_mask ports absent; all elements below vl are active.
// STRUCTURE
//  Shared package rvv_wb_pkg: state encoding, SEW codes, per-lane field widths
//    (LANE_DATA_W=64, LANE_IDX_W=10), VLEN byte-count helper.
//  Sub-module rvv_wb_elem_place (combinational, one per lane):
//    (idx, vsew, data, en) -> VLEN-wide placed data plus VLEN/8 byte mask.
//    Parent merges lanes in ascending order into buf/be.
// TESTING (VLEN=128, NB_LANES=1)
//  vsew=0, vl=16, 2 lanes send idx 2k/2k+1 with data idx+1 over 8 cycles -> wr_data=0x100F..0201,
//    wr_be=16'hFFFF.
//  vsew=2, vl=3, vd_old=all 0xAA, data 0x11111111/0x22222222/0x33333333 -> bits[127:96]=0xAAAAAAAA,
//    wr_be=16'h0FFF.
//  RVV_WB_MASK_EN: vm=0, v0_mask=4'b0101, vsew=2, vl=4 -> only elements 0,2 written, wr_be=16'h0F0F.
//  wr_ready low for 5 cycles -> wr_valid held, wr_data stable, start ignored, done 1 cycle after accept.
//  vl=0 -> no wr_valid, done pulse 1 cycle after start. Out-of-range idx=20 (vsew=0) -> buffer unchanged.
//  resetn low in COLLECT -> next cycle busy=0, wr_valid=0, no done. A new start then runs normally.

Source files
------------

// File: rtl/rvv_wb_pkg.sv
// rvv_wb_pkg: shared state encoding, SEW codes, lane field widths and sizing helpers
// for the vector destination writeback block (optional v0 masking: RVV_WB_MASK_EN).
package rvv_wb_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_WRITE
    } state_e;

    typedef enum logic [2:0] {
        SEW8  = 3'd0,
        SEW16 = 3'd1,
        SEW32 = 3'd2,
        SEW64 = 3'd3
    } sew_e;

    localparam int LANE_DATA_W = 64;
    localparam int LANE_IDX_W  = 10;

    function automatic int vlen_bytes(input int vlen);
        return vlen / 8;
    endfunction

    // Number of SEW-wide elements that fit in one vector register.
    function automatic logic [10:0] elem_cap(input int vlen, input logic [1:0] vsew);
        return 11'(vlen >> (int'(vsew) + 3));
    endfunction

endpackage

// File: rtl/rvv_vd_writeback_if.sv
// rvv_vd_writeback_if: valid/ready write port from the writeback block to the vector register file.
interface rvv_vd_writeback_if
    import rvv_wb_pkg::*;
#(
    parameter int VLEN = 128
) ();

    logic                        wr_valid;
    logic                        wr_ready;
    logic [VLEN-1:0]             wr_data;
    logic [vlen_bytes(VLEN)-1:0] wr_be;

    modport master (output wr_valid, wr_data, wr_be, input wr_ready);
    modport slave  (input wr_valid, wr_data, wr_be, output wr_ready);

endinterface

// File: rtl/rvv_wb_elem_place.sv
// rvv_wb_elem_place: positions one lane's SEW-wide element inside a VLEN-wide word with its byte mask.
module rvv_wb_elem_place
    import rvv_wb_pkg::*;
#(
    parameter int VLEN = 128
) (
    input  logic [LANE_IDX_W-1:0]       idx_i,
    input  logic [1:0]                  vsew_i,
    input  logic [LANE_DATA_W-1:0]      data_i,
    input  logic                        en_i,
    output logic [VLEN-1:0]             data_o,
    output logic [vlen_bytes(VLEN)-1:0] be_o
);

    localparam int NB = vlen_bytes(VLEN);

    logic [LANE_DATA_W-1:0] elem;
    logic [7:0]             bmask;
    logic [13:0]            byte_off;
    logic [16:0]            bit_off;

    // Only the low SEW bits of the lane slot belong to the element.
    assign elem     = data_i & ((vsew_i == 2'd3) ? '1 : ((64'd1 << (8 << vsew_i)) - 64'd1));
    assign bmask    = 8'((9'd1 << (1 << vsew_i)) - 9'd1);
    assign byte_off = 14'(idx_i) << vsew_i;
    assign bit_off  = {byte_off, 3'b000};
    assign data_o   = en_i ? (VLEN'(elem) << bit_off) : '0;
    assign be_o     = en_i ? (NB'(bmask) << byte_off) : '0;

endmodule

// File: rtl/rvv_vd_writeback.sv
// rvv_vd_writeback: gathers lane element results into a vd buffer seeded with old vd and
// issues a single byte-enabled register-file write; v0 masking enabled by RVV_WB_MASK_EN.
module rvv_vd_writeback
    import rvv_wb_pkg::*;
#(
    parameter int VLEN     = 128,
    parameter int NB_LANES = 1
) (
    input  logic                                clk,
    input  logic                                resetn,
    input  logic                                start_i,
    input  logic [VLEN-1:0]                     vd_old_i,
    input  logic [2:0]                          vsew_i,
    input  logic [10:0]                         vl_i,
    input  logic [(LANE_DATA_W<<NB_LANES)-1:0]  lane_vd_i,
    input  logic [(LANE_IDX_W<<NB_LANES)-1:0]   lane_idx_i,
    input  logic [(1<<NB_LANES)-1:0]            lane_valid_i,
    input  logic                                alu_done_i,
`ifdef RVV_WB_MASK_EN
    input  logic                                vm_i,
    input  logic [VLEN-1:0]                     v0_mask_i,
`endif
    rvv_vd_writeback_if.master                  wr,
    output logic                                busy_o,
    output logic                                done_o
);

    localparam int NL = 1 << NB_LANES;
    localparam int NB = vlen_bytes(VLEN);

    state_e          state_q, state_d;
    logic [VLEN-1:0] buf_q, buf_d, mrg_buf;
    logic [NB-1:0]   be_q, be_d, mrg_be;
    logic [1:0]      vsew_q, vsew_d;
    logic [10:0]     vl_q, vl_d, lim;
    logic            done_q, done_d, no_work;
`ifdef RVV_WB_MASK_EN
    logic            vm_q, vm_d;
    logic [VLEN-1:0] v0_q, v0_d;
`endif

    logic            en    [NL];
    logic [VLEN-1:0] pdata [NL];
    logic [NB-1:0]   pbe   [NL];

    assign no_work = (vsew_i > 3'd3) || (vl_i == 11'd0);
    assign lim     = (vl_q < elem_cap(VLEN, vsew_q)) ? vl_q : elem_cap(VLEN, vsew_q);

    for (genvar j = 0; j < NL; j++) begin : g_lane
        logic [LANE_IDX_W-1:0] idx;
        assign idx = lane_idx_i[j*LANE_IDX_W +: LANE_IDX_W];
`ifdef RVV_WB_MASK_EN
        assign en[j] = lane_valid_i[j] && ({1'b0, idx} < lim) && (vm_q || |(v0_q & (VLEN'(1) << idx)));
`else
        assign en[j] = lane_valid_i[j] && ({1'b0, idx} < lim);
`endif
        rvv_wb_elem_place #(.VLEN(VLEN)) u_place (
            .idx_i  (idx),
            .vsew_i (vsew_q),
            .data_i (lane_vd_i[j*LANE_DATA_W +: LANE_DATA_W]),
            .en_i   (en[j]),
            .data_o (pdata[j]),
            .be_o   (pbe[j])
        );
    end

    // Fold placed lane results into the buffer in ascending lane order so the highest lane wins.
    always_comb begin
        mrg_buf = buf_q;
        mrg_be  = be_q;
        for (int j = 0; j < NL; j++) begin
            for (int k = 0; k < NB; k++)
                if (pbe[j][k]) mrg_buf[8*k +: 8] = pdata[j][8*k +: 8];
            mrg_be = mrg_be | pbe[j];
        end
    end

    // Next state: latch the instruction on start, gather results, hold the write until accepted.
    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        be_d    = be_q;
        vsew_d  = vsew_q;
        vl_d    = vl_q;
        done_d  = 1'b0;
`ifdef RVV_WB_MASK_EN
        vm_d    = vm_q;
        v0_d    = v0_q;
`endif
        case (state_q)
            S_IDLE: if (start_i) begin
                buf_d   = vd_old_i;
                be_d    = '0;
                vsew_d  = vsew_i[1:0];
                vl_d    = vl_i;
`ifdef RVV_WB_MASK_EN
                vm_d    = vm_i;
                v0_d    = v0_mask_i;
`endif
                done_d  = no_work;
                state_d = no_work ? S_IDLE : S_COLLECT;
            end
            S_COLLECT: begin
                buf_d   = mrg_buf;
                be_d    = mrg_be;
                state_d = alu_done_i ? S_WRITE : S_COLLECT;
            end
            S_WRITE: if (wr.wr_ready) begin
                state_d = S_IDLE;
                done_d  = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset drops any pending write without a done pulse.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            buf_q   <= '0;
            be_q    <= '0;
            vsew_q  <= '0;
            vl_q    <= '0;
            done_q  <= 1'b0;
`ifdef RVV_WB_MASK_EN
            vm_q    <= 1'b1;
            v0_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            be_q    <= be_d;
            vsew_q  <= vsew_d;
            vl_q    <= vl_d;
            done_q  <= done_d;
`ifdef RVV_WB_MASK_EN
            vm_q    <= vm_d;
            v0_q    <= v0_d;
`endif
        end
    end

    assign wr.wr_valid = (state_q == S_WRITE);
    assign wr.wr_data  = buf_q;
    assign wr.wr_be    = be_q;
    assign busy_o      = (state_q != S_IDLE);
    assign done_o      = done_q;

endmodule

// File: tb/tb_rvv_vd_writeback.sv
// tb_rvv_vd_writeback: directed and randomized checks of rvv_vd_writeback against a byte-level reference model.
module tb_rvv_vd_writeback;

    logic         clk = 1'b0;
    logic         resetn, start, alu_done, vm;
    logic [127:0] vd_old, v0_mask, lane_vd;
    logic [2:0]   vsew;
    logic [10:0]  vl;
    logic [19:0]  lane_idx;
    logic [1:0]   lane_valid;
    logic         busy, done;

    int total = 0;
    int bad   = 0;

    rvv_vd_writeback_if #(.VLEN(128)) wr ();

    rvv_vd_writeback #(.VLEN(128), .NB_LANES(1)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .start_i      (start),
        .vd_old_i     (vd_old),
        .vsew_i       (vsew),
        .vl_i         (vl),
        .lane_vd_i    (lane_vd),
        .lane_idx_i   (lane_idx),
        .lane_valid_i (lane_valid),
        .alu_done_i   (alu_done),
`ifdef RVV_WB_MASK_EN
        .vm_i         (vm),
        .v0_mask_i    (v0_mask),
`endif
        .wr           (wr.master),
        .busy_o       (busy),
        .done_o       (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: phase 0=idle, 1=gathering, 2=write pending; vd kept as a byte image.
    int           m_ph   = 0;
    bit           m_done = 1'b0;
    bit           armed  = 1'b0;
    logic [127:0] m_buf  = '0;
    logic [15:0]  m_be   = '0;
    int           m_sew, m_vl;
    bit           m_vm;
    logic [127:0] m_v0;

    always @(posedge clk) begin
        bit nd;
        armed = 1'b1;
        nd    = 1'b0;
        if (!resetn) begin
            m_ph  = 0;
            m_buf = '0;
            m_be  = '0;
        end else if (m_ph == 0) begin
            if (start) begin
                m_buf = vd_old;
                m_be  = '0;
                m_sew = int'(vsew);
                m_vl  = int'(vl);
                m_vm  = vm;
                m_v0  = v0_mask;
                if (vsew > 3 || vl == 0) nd = 1'b1;
                else m_ph = 1;
            end
        end else if (m_ph == 1) begin
            for (int j = 0; j < 2; j++) begin
                int idx;
                bit act;
                idx = int'(lane_idx[10*j +: 10]);
`ifdef RVV_WB_MASK_EN
                act = m_vm || (idx < 128 && m_v0[idx]);
`else
                act = 1'b1;
`endif
                if (lane_valid[j] && idx < m_vl && idx < (16 >> m_sew) && act)
                    for (int b = 0; b < (1 << m_sew); b++) begin
                        m_buf[8*((idx << m_sew) + b) +: 8] = lane_vd[64*j + 8*b +: 8];
                        m_be[(idx << m_sew) + b]          = 1'b1;
                    end
            end
            if (alu_done) m_ph = 2;
        end else if (wr.wr_ready) begin
            m_ph = 0;
            nd   = 1'b1;
        end
        m_done = nd;
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (armed) begin
            chk("busy", 128'(busy), 128'(m_ph != 0));
            chk("wr_valid", 128'(wr.wr_valid), 128'(m_ph == 2));
            chk("done", 128'(done), 128'(m_done));
            if (m_ph == 2) begin
                chk("wr_data", wr.wr_data, m_buf);
                chk("wr_be", 128'(wr.wr_be), 128'(m_be));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [127:0] d, input logic [2:0] s, input logic [10:0] l);
        start  = 1'b1;
        vd_old = d;
        vsew   = s;
        vl     = l;
        tick();
        start  = 1'b0;
    endtask

    task automatic lanes(input logic [1:0] v, input logic [9:0] i0, input logic [63:0] d0,
                         input logic [9:0] i1, input logic [63:0] d1, input logic ad);
        lane_valid = v;
        lane_idx   = {i1, i0};
        lane_vd    = {d1, d0};
        alu_done   = ad;
        tick();
        lane_valid = '0;
        alu_done   = 1'b0;
    endtask

    localparam logic [127:0] PAT = 128'h0123456789ABCDEF_FEDCBA9876543210;

    initial begin
        resetn = 1'b0; start = 1'b0; alu_done = 1'b0; vm = 1'b1; v0_mask = '0;
        vd_old = '0; vsew = '0; vl = '0; lane_vd = '0; lane_idx = '0; lane_valid = '0;
        wr.wr_ready = 1'b1;
        repeat (3) tick();
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_valid", 128'(wr.wr_valid), 128'd0);
        chk("rst_done", 128'(done), 128'd0);
        chk("rst_data", wr.wr_data, 128'd0);
        chk("rst_be", 128'(wr.wr_be), 128'd0);
        resetn = 1'b1;
        tick();

        do_start('0, 3'd0, 11'd16);
        for (int k = 0; k < 8; k++)
            lanes(2'b11, 10'(2*k), 64'(2*k+1), 10'(2*k+1), 64'(2*k+2), k == 7);
        chk("t1_latency", 128'(wr.wr_valid), 128'd1);
        chk("t1_data", wr.wr_data, 128'h100F0E0D0C0B0A090807060504030201);
        chk("t1_model", m_buf, 128'h100F0E0D0C0B0A090807060504030201);
        chk("t1_be", 128'(wr.wr_be), 128'hFFFF);
        tick();
        chk("t1_done", 128'(done), 128'd1);
        tick();
        chk("t1_done_end", 128'(done), 128'd0);

        do_start({16{8'hAA}}, 3'd2, 11'd3);
        wr.wr_ready = 1'b0;
        lanes(2'b11, 10'd0, 64'hDEADBEEF11111111, 10'd1, 64'h22222222, 1'b0);
        lanes(2'b11, 10'd2, 64'h33333333, 10'd3, 64'h44444444, 1'b1);
        chk("t2_data", wr.wr_data, 128'hAAAAAAAA333333332222222211111111);
        chk("t2_model", m_buf, 128'hAAAAAAAA333333332222222211111111);
        chk("t2_be", 128'(wr.wr_be), 128'h0FFF);
        for (int k = 0; k < 5; k++) begin
            start = 1'b1; vl = 11'd5;
            tick();
            chk("t2_hold_valid", 128'(wr.wr_valid), 128'd1);
            chk("t2_hold_data", wr.wr_data, 128'hAAAAAAAA333333332222222211111111);
        end
        start = 1'b0;
        wr.wr_ready = 1'b1;
        tick();
        chk("t2_done", 128'(done), 128'd1);
        chk("t2_idle", 128'(busy), 128'd0);
        tick();

        do_start('0, 3'd0, 11'd0);
        chk("vl0_done", 128'(done), 128'd1);
        chk("vl0_busy", 128'(busy), 128'd0);
        tick();
        chk("vl0_done_end", 128'(done), 128'd0);

        do_start(PAT, 3'd0, 11'd16);
        lanes(2'b01, 10'd20, 64'hFF, 10'd0, 64'd0, 1'b1);
        chk("oor_data", wr.wr_data, PAT);
        chk("oor_be", 128'(wr.wr_be), 128'd0);
        tick();
        tick();

        do_start('0, 3'd1, 11'd8);
        lanes(2'b01, 10'd0, 64'h1234, 10'd0, 64'd0, 1'b0);
        resetn = 1'b0;
        tick();
        chk("rstc_busy", 128'(busy), 128'd0);
        chk("rstc_valid", 128'(wr.wr_valid), 128'd0);
        chk("rstc_done", 128'(done), 128'd0);
        resetn = 1'b1;
        tick();
        chk("rstc_nodone", 128'(done), 128'd0);
        do_start(PAT, 3'd1, 11'd8);
        lanes(2'b11, 10'd0, 64'hBEEF, 10'd7, 64'hCAFE, 1'b1);
        chk("rstc_data", wr.wr_data, {16'hCAFE, PAT[111:16], 16'hBEEF});
        chk("rstc_be", 128'(wr.wr_be), 128'hC003);
        tick();
        chk("rstc_done2", 128'(done), 128'd1);
        tick();

`ifdef RVV_WB_MASK_EN
        vm = 1'b0;
        v0_mask = 128'b0101;
        do_start('0, 3'd2, 11'd4);
        lanes(2'b11, 10'd0, 64'd1, 10'd1, 64'd2, 1'b0);
        lanes(2'b11, 10'd2, 64'd3, 10'd3, 64'd4, 1'b1);
        chk("mask_be", 128'(wr.wr_be), 128'h0F0F);
        chk("mask_data", wr.wr_data, 128'h00000000000000030000000000000001);
        vm = 1'b1;
        tick();
        tick();
`endif

        for (int c = 0; c < 3000; c++) begin
            resetn      = ($urandom_range(0, 199) != 0);
            start       = ($urandom_range(0, 3) == 0);
            vd_old      = {$urandom, $urandom, $urandom, $urandom};
            vsew        = 3'($urandom_range(0, 4));
            vl          = 11'($urandom_range(0, 18));
            lane_valid  = 2'($urandom);
            lane_idx    = {10'($urandom_range(0, 19)), 10'($urandom_range(0, 19))};
            lane_vd     = {$urandom, $urandom, $urandom, $urandom};
            alu_done    = ($urandom_range(0, 5) == 0);
            wr.wr_ready = ($urandom_range(0, 9) < 7);
            vm          = 1'($urandom);
            v0_mask     = {$urandom, $urandom, $urandom, $urandom};
            tick();
        end
        resetn = 1'b1; start = 1'b0; lane_valid = '0; alu_done = 1'b0; wr.wr_ready = 1'b1;
        repeat (4) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
